// File: rtl/sdc_cmd_controller.sv
// SD command-phase sequencer: builds and serialises a 48-bit command frame,
// then optionally captures a 48-bit response through the external shift register.
module sdc_cmd_controller #(
    parameter int unsigned RESP_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_expected,
    output logic        busy,
    output logic        done,
    output logic [47:0] resp_data,
    output logic        resp_timeout,
    output logic        resp_crc_err,
    output logic        resp_end_err,
    output logic        sr_load,
    output logic        sr_shift,
    output logic [47:0] sr_data_p,
    output logic        sr_data_s,
    input  logic [47:0] sr_data,
    output logic        sdc_cmd_out,
    output logic        sdc_cmd_oe,
    input  logic        sdc_cmd_in
);

    localparam int unsigned CNT_W  = 6;
    localparam int unsigned WAIT_W = 8;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(47);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESP_TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TX   = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_RX   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // CRC7 (x^7 + x^3 + 1, init 0) over 40 bits, MSB first
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              resp_exp_q, resp_exp_nxt;
    logic              timeout_q, timeout_nxt;
    logic              done_nxt;
    logic [47:0]       resp_data_nxt;
    logic              resp_timeout_nxt, resp_crc_err_nxt, resp_end_err_nxt;
    logic [39:0]       cmd_head;

    assign cmd_head  = {2'b01, cmd_index, cmd_arg};
    assign sr_data_p = {cmd_head, crc7(cmd_head), 1'b1};
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            wait_cnt     <= '0;
            resp_exp_q   <= 1'b0;
            timeout_q    <= 1'b0;
            done         <= 1'b0;
            resp_data    <= '0;
            resp_timeout <= 1'b0;
            resp_crc_err <= 1'b0;
            resp_end_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            wait_cnt     <= wait_cnt_nxt;
            resp_exp_q   <= resp_exp_nxt;
            timeout_q    <= timeout_nxt;
            done         <= done_nxt;
            resp_data    <= resp_data_nxt;
            resp_timeout <= resp_timeout_nxt;
            resp_crc_err <= resp_crc_err_nxt;
            resp_end_err <= resp_end_err_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        bit_cnt_nxt      = bit_cnt;
        wait_cnt_nxt     = wait_cnt;
        resp_exp_nxt     = resp_exp_q;
        timeout_nxt      = timeout_q;
        done_nxt         = 1'b0;
        resp_data_nxt    = resp_data;
        resp_timeout_nxt = resp_timeout;
        resp_crc_err_nxt = resp_crc_err;
        resp_end_err_nxt = resp_end_err;
        sr_load          = 1'b0;
        sr_shift         = 1'b0;
        sr_data_s        = 1'b1;
        sdc_cmd_out      = 1'b1;
        sdc_cmd_oe       = 1'b0;

        case (state)
            ST_IDLE: begin
                sr_load = start;
                if (start) begin
                    state_nxt    = ST_TX;
                    bit_cnt_nxt  = '0;
                    wait_cnt_nxt = '0;
                    resp_exp_nxt = resp_expected;
                    timeout_nxt  = 1'b0;
                end
            end
            ST_TX: begin
                sdc_cmd_oe  = 1'b1;
                sdc_cmd_out = sr_data[47];
                sr_shift    = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = resp_exp_q ? ST_WAIT : ST_DONE;
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                // A start bit seen on the last allowed cycle still wins over timeout
                if (!sdc_cmd_in) begin
                    sr_shift    = 1'b1;
                    sr_data_s   = 1'b0;
                    bit_cnt_nxt = CNT_W'(1);
                    state_nxt   = ST_RX;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_DONE;
                end
            end
            ST_RX: begin
                sr_shift  = 1'b1;
                sr_data_s = sdc_cmd_in;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = ST_DONE;
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                done_nxt         = 1'b1;
                state_nxt        = ST_IDLE;
                resp_timeout_nxt = timeout_q;
                if (resp_exp_q && !timeout_q) begin
                    resp_data_nxt    = sr_data;
                    resp_crc_err_nxt = (crc7(sr_data[47:8]) != sr_data[7:1]);
                    resp_end_err_nxt = !sr_data[0];
                end else begin
                    resp_data_nxt    = '0;
                    resp_crc_err_nxt = 1'b0;
                    resp_end_err_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
